// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - instruction prefetch stage: PC, imem req/gnt/rvalid fetch, instruction buffer, jump flush
module ifu_prefetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] jump_addr_i,
    input  logic        jump_en_i,
    input  logic        hold_flag_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_ready_i
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);
    localparam logic [31:0] PC_RESET = {RESET_ADDR[31:2], 2'b00};

    logic [31:0]   pc_q, pc_d;
    logic          pend_q, pend_d;
    logic [31:0]   pend_addr_q, pend_addr_d;
    logic          stale_q, stale_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] tag_wr_q, tag_wr_d;
    logic [AW-1:0] tag_rd_q, tag_rd_d;

    logic [31:0] fifo_addr_q [FIFO_DEPTH];
    logic [31:0] fifo_data_q [FIFO_DEPTH];
    logic [31:0] tag_q       [FIFO_DEPTH];

    logic room;
    logic gnt_fire;
    logic rsp_drop;
    logic fifo_push;
    logic fifo_pop;
    logic unused_jump_lsb;

    assign unused_jump_lsb = ^jump_addr_i[1:0];

    assign room        = ({1'b0, cnt_q} + {1'b0, outst_q}) < DEPTH_W;
    // A pending request is held stable until granted, regardless of hold or jump.
    assign imem_req_o  = rst_n && (pend_q || (!hold_flag_i && room));
    assign imem_addr_o = pend_q ? pend_addr_q : pc_q;
    assign gnt_fire    = imem_req_o && imem_gnt_i;

    assign rsp_drop  = imem_rvalid_i && ((drop_q != '0) || jump_en_i);
    assign fifo_push = imem_rvalid_i && !rsp_drop;

    assign inst_valid_o = (cnt_q != '0) && !hold_flag_i && !jump_en_i;
    assign fifo_pop     = inst_valid_o && inst_ready_i;
    assign inst_o       = fifo_data_q[rd_ptr_q];
    assign inst_addr_o  = fifo_addr_q[rd_ptr_q];

    always_comb begin
        pc_d        = pc_q;
        pend_d      = imem_req_o && !gnt_fire;
        pend_addr_d = imem_addr_o;
        stale_d     = stale_q;
        outst_d     = outst_q + CW'(gnt_fire) - CW'(imem_rvalid_i);
        drop_d      = drop_q;
        cnt_d       = cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        tag_wr_d    = tag_wr_q + AW'(gnt_fire);
        tag_rd_d    = tag_rd_q + AW'(imem_rvalid_i);

        // A granted stale request belongs to the old stream: it is dropped and does not advance the PC.
        if (gnt_fire && !stale_q) begin
            pc_d = pc_q + 32'd4;
        end

        if (jump_en_i) begin
            pc_d     = {jump_addr_i[31:2], 2'b00};
            drop_d   = outst_d;
            stale_d  = imem_req_o && !gnt_fire;
            cnt_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            drop_d   = drop_q + CW'(gnt_fire && stale_q)
                       - CW'(imem_rvalid_i && (drop_q != '0));
            stale_d  = stale_q && !gnt_fire;
            cnt_d    = cnt_q + CW'(fifo_push) - CW'(fifo_pop);
            wr_ptr_d = wr_ptr_q + AW'(fifo_push);
            rd_ptr_d = rd_ptr_q + AW'(fifo_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= PC_RESET;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            stale_q     <= 1'b0;
            outst_q     <= '0;
            drop_q      <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            tag_wr_q    <= '0;
            tag_rd_q    <= '0;
        end else begin
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            stale_q     <= stale_d;
            outst_q     <= outst_d;
            drop_q      <= drop_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            tag_wr_q    <= tag_wr_d;
            tag_rd_q    <= tag_rd_d;
        end
    end

    // Tag queue records the address of each granted fetch; responses return in order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
                tag_q[i]       <= '0;
            end
        end else begin
            if (fifo_push) begin
                fifo_addr_q[wr_ptr_q] <= tag_q[tag_rd_q];
                fifo_data_q[wr_ptr_q] <= imem_rdata_i;
            end
            if (gnt_fire) begin
                tag_q[tag_wr_q] <= imem_addr_o;
            end
        end
    end

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb/tb_ifu_prefetch.sv - self-checking bench for ifu_prefetch: vector table, directed corners, randomized model check
module tb_ifu_prefetch;

    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] jump_addr = '0;
    logic        jump_en = 1'b0;
    logic        hold = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        ready = 1'b0;

    always #5 clk = ~clk;

    ifu_prefetch #(.RESET_ADDR(32'h0000_0000), .FIFO_DEPTH(D)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .jump_addr_i  (jump_addr),
        .jump_en_i    (jump_en),
        .hold_flag_i  (hold),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (gnt),
        .imem_rvalid_i(rvalid),
        .imem_rdata_i (rdata),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .inst_ready_i (ready)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct { logic [31:0] addr; logic [31:0] data; } inst_t;
    typedef struct { logic [31:0] addr; logic drop; } out_t;
    typedef struct { logic [31:0] addr; int due; } mem_t;

    typedef struct {
        logic        hold;
        logic        jump;
        logic [31:0] jaddr;
        logic        ready;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_iaddr;
        logic [31:0] e_inst;
    } vec_t;

    // Reference model: PC, pending request, in-flight fetches with a per-fetch drop mark, buffer contents.
    logic [31:0] m_pc;
    logic        m_pend;
    logic [31:0] m_pend_addr;
    logic        m_pend_stale;
    inst_t       m_fifo[$];
    out_t        m_out[$];
    mem_t        mem_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_invariants();
        chk("cnt_plus_outstanding_le_depth",
            32'(int'(dut.cnt_q) + int'(dut.outst_q) <= D), 32'd1);
        chk("drop_le_depth", 32'(int'(dut.drop_q) <= D), 32'd1);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        gnt = 1'b0; rvalid = 1'b0; rdata = '0; jump_en = 1'b0; hold = 1'b0; ready = 1'b0;
        #1;
        chk("rst_req", {31'b0, imem_req_o}, 32'd0);
        chk("rst_valid", {31'b0, inst_valid_o}, 32'd0);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_inst_addr", inst_addr_o, 32'd0);
        m_pc = 32'h0; m_pend = 1'b0; m_pend_addr = '0; m_pend_stale = 1'b0;
        m_fifo.delete(); m_out.delete(); mem_q.delete();
        @(posedge clk); cyc++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One cycle with model checking; gmode 0 never/1 always/2 random grant, rmode 1 earliest/2 random response.
    task automatic step(input logic h, input logic j, input logic [31:0] ja, input logic r,
                        input int gmode, input int rmode);
        logic        e_req, e_valid, g, rv, sd;
        logic [31:0] e_addr, rd;
        out_t        e;
        hold = h; jump_en = j; jump_addr = ja; ready = r; gnt = 1'b0;
        rv = 1'b0; rd = '0;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc && (rmode == 1 || $urandom_range(0, 3) != 0)) begin
            rv = 1'b1;
            rd = mem_word(mem_q[0].addr);
        end
        rvalid = rv; rdata = rd;
        e_req   = m_pend || (!h && (m_fifo.size() + m_out.size() < D));
        e_addr  = m_pend ? m_pend_addr : m_pc;
        e_valid = (m_fifo.size() > 0) && !h && !j;
        #1;
        g = imem_req_o && (gmode == 1 || (gmode == 2 && $urandom_range(0, 2) != 0));
        gnt = g;
        #1;
        chk("req", {31'b0, imem_req_o}, {31'b0, e_req});
        if (e_req) chk("addr", imem_addr_o, e_addr);
        chk("valid", {31'b0, inst_valid_o}, {31'b0, e_valid});
        if (e_valid) begin
            chk("inst_addr", inst_addr_o, m_fifo[0].addr);
            chk("inst", inst_o, m_fifo[0].data);
        end
        chk_invariants();
        if (e_valid && r) void'(m_fifo.pop_front());
        if (rv) begin
            e = m_out.pop_front();
            void'(mem_q.pop_front());
            if (!e.drop && !j) m_fifo.push_back('{e.addr, mem_word(e.addr)});
        end
        if (g) begin
            sd = m_pend && m_pend_stale;
            m_out.push_back('{e_addr, sd || j});
            mem_q.push_back('{e_addr, cyc + 1 + ((rmode == 2) ? int'($urandom_range(0, 2)) : 0)});
            if (!sd) m_pc = m_pc + 32'd4;
        end
        if (j) begin
            m_fifo.delete();
            foreach (m_out[i]) m_out[i].drop = 1'b1;
            m_pc = {ja[31:2], 2'b00};
        end
        if (e_req && !g) begin
            m_pend_stale = (m_pend && m_pend_stale) || j;
            m_pend       = 1'b1;
            m_pend_addr  = e_addr;
        end else begin
            m_pend       = 1'b0;
            m_pend_stale = 1'b0;
        end
        @(posedge clk); cyc++;
        @(negedge clk);
    endtask

    vec_t tv[13];

    initial begin
        //          hold jump jaddr         rdy gnt rv  rdata          e_req e_addr        e_val e_iaddr       e_inst
        tv[0]  = '{1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 1'b0, 32'h0,          1'b1, 32'h0,    1'b0, 32'h0,    32'h0};
        tv[1]  = '{1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 1'b1, 32'hC0DE_0000,  1'b1, 32'h4,    1'b0, 32'h0,    32'h0};
        tv[2]  = '{1'b0, 1'b0, 32'h0,      1'b1, 1'b0, 1'b1, 32'hC0DE_0004,  1'b0, 32'h8,    1'b1, 32'h0,    32'hC0DE_0000};
        tv[3]  = '{1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 1'b0, 32'h0,          1'b1, 32'h8,    1'b1, 32'h4,    32'hC0DE_0004};
        tv[4]  = '{1'b0, 1'b0, 32'h0,      1'b0, 1'b1, 1'b1, 32'hC0DE_0008,  1'b1, 32'hC,    1'b0, 32'h0,    32'h0};
        tv[5]  = '{1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b1, 32'hC0DE_000C,  1'b0, 32'h10,   1'b1, 32'h8,    32'hC0DE_0008};
        tv[6]  = '{1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 32'h0,          1'b0, 32'h10,   1'b1, 32'h8,    32'hC0DE_0008};
        tv[7]  = '{1'b1, 1'b0, 32'h0,      1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 32'h10,   1'b0, 32'h0,    32'h0};
        tv[8]  = '{1'b0, 1'b1, 32'h1003,   1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 32'h10,   1'b0, 32'h0,    32'h0};
        tv[9]  = '{1'b0, 1'b0, 32'h0,      1'b1, 1'b0, 1'b0, 32'h0,          1'b1, 32'h1000, 1'b0, 32'h0,    32'h0};
        tv[10] = '{1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 1'b0, 32'h0,          1'b1, 32'h1000, 1'b0, 32'h0,    32'h0};
        tv[11] = '{1'b0, 1'b0, 32'h0,      1'b1, 1'b0, 1'b1, 32'hC0DE_1000,  1'b1, 32'h1004, 1'b0, 32'h0,    32'h0};
        tv[12] = '{1'b0, 1'b0, 32'h0,      1'b1, 1'b0, 1'b0, 32'h0,          1'b1, 32'h1004, 1'b1, 32'h1000, 32'hC0DE_1000};

        do_reset();

        for (int i = 0; i < 13; i++) begin
            hold = tv[i].hold; jump_en = tv[i].jump; jump_addr = tv[i].jaddr; ready = tv[i].ready;
            gnt = tv[i].gnt; rvalid = tv[i].rvalid; rdata = tv[i].rdata;
            #2;
            chk($sformatf("vec%0d_req", i), {31'b0, imem_req_o}, {31'b0, tv[i].e_req});
            if (tv[i].e_req) chk($sformatf("vec%0d_addr", i), imem_addr_o, tv[i].e_addr);
            chk($sformatf("vec%0d_valid", i), {31'b0, inst_valid_o}, {31'b0, tv[i].e_valid});
            if (tv[i].e_valid) begin
                chk($sformatf("vec%0d_inst_addr", i), inst_addr_o, tv[i].e_iaddr);
                chk($sformatf("vec%0d_inst", i), inst_o, tv[i].e_inst);
            end
            @(posedge clk); cyc++;
            @(negedge clk);
        end

        // Async reset with a request still pending from the table.
        do_reset();

        // Jump while the first request is stalled without grant, target at the top of memory.
        step(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 0, 1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 0, 1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 0, 1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1, 1);

        // Fill the buffer, hold for 5 cycles, then drain.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1, 1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1, 1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1, 1);

        // Jump with two fetches in flight.
        step(1'b0, 1'b0, 32'h0, 1'b0, 1, 2);
        step(1'b0, 1'b1, 32'h0000_1003, 1'b1, 0, 2);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1, 2);

        for (int i = 0; i < 3000; i++) begin
            logic        h, j, r;
            logic [31:0] ja;
            h  = ($urandom_range(0, 5) == 0);
            j  = ($urandom_range(0, 15) == 0);
            r  = ($urandom_range(0, 3) != 0);
            ja = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom();
            step(h, j, ja, r, 2, 2);
            if (i % 1000 == 999) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
